// File: rtl/pipe_pkg.sv
// Shared widths, control-bit positions and ID/EX packing helper
// for the elastic inter-stage registers.
package pipe_pkg;

    localparam int IF_CTRL_W  = 8;
    localparam int IF_DATA_W  = 64;
    localparam int ID_CTRL_W  = 8;
    localparam int ID_DATA_W  = 96;
    localparam int EX_CTRL_W  = 8;
    localparam int EX_DATA_W  = 96;
    localparam int MEM_CTRL_W = 8;
    localparam int MEM_DATA_W = 64;

    localparam int CTRL_WB_EN = 0;
    localparam int CTRL_MEM_R = 1;
    localparam int CTRL_MEM_W = 2;
    localparam int CTRL_S     = 3;
    localparam int CTRL_B     = 4;
    localparam int CTRL_IMM   = 5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rm;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [3:0]  exec_cmd;
    } id_ex_data_t;

    function automatic logic [ID_DATA_W-1:0] pack_id_ex(
        input logic [31:0] pc,
        input logic [31:0] val_rm,
        input logic [23:0] imm24,
        input logic [3:0]  dest,
        input logic [3:0]  exec_cmd
    );
        id_ex_data_t d;
        d.pc       = pc;
        d.val_rm   = val_rm;
        d.imm24    = imm24;
        d.dest     = dest;
        d.exec_cmd = exec_cmd;
        return d;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data holding register; a cleared slot reads all-zero.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_CTRL_W,
    parameter int DATA_W = ID_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: head slot plus optional skid slot,
// flush/freeze control and a saturating flush-drop counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_CTRL_W,
    parameter int DATA_W = ID_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic              go;
    logic              accept;
    logic              drain;
    logic              m_valid;
    logic              m_load;
    logic              m_clear;
    logic              m_from_s;
    logic [CTRL_W-1:0] m_ctrl_in;
    logic [DATA_W-1:0] m_data_in;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic [CNT_W:0]    drop_sum;

    assign go        = ~freeze & ~flush;
    assign out_valid = m_valid & go;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // A draining head refills from the skid slot first to keep FIFO order.
    assign m_from_s  = drain & s_valid;
    assign m_load    = m_from_s | (accept & (drain | ~m_valid));
    assign m_clear   = flush | (drain & ~s_valid & ~accept);
    assign m_ctrl_in = m_from_s ? s_ctrl : in_ctrl;
    assign m_data_in = m_from_s ? s_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) m_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (m_load),
        .clear   (m_clear),
        .in_ctrl (m_ctrl_in),
        .in_data (m_data_in),
        .valid   (m_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic s_load;
            logic s_clear;

            assign s_load   = accept & ~drain & m_valid;
            assign s_clear  = flush | m_from_s;
            // Registered ready: no path from out_ready.
            assign in_ready = ~s_valid & go;

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) s_slot (
                .clk     (clk),
                .rst     (rst),
                .load    (s_load),
                .clear   (s_clear),
                .in_ctrl (in_ctrl),
                .in_data (in_data),
                .valid   (s_valid),
                .ctrl    (s_ctrl),
                .data    (s_data)
            );
        end else begin : g_noskid
            assign s_valid  = 1'b0;
            assign s_ctrl   = '0;
            assign s_data   = '0;
            assign in_ready = (~m_valid | out_ready) & go;
        end
    endgenerate

    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
    assign drop_sum  = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, occupancy};

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 builds side by side,
// compared every cycle against queue-based reference models.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        freeze = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [95:0] in_data = '0;

    logic        rdy1, val1, rdy0, val0;
    logic [7:0]  ctl1, ctl0, drp1, drp0;
    logic [95:0] dat1, dat0;
    logic [1:0]  occ1, occ0;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(val1), .out_ready(out_ready),
        .out_ctrl(ctl1), .out_data(dat1),
        .occupancy(occ1), .drop_cnt(drp1)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(val0), .out_ready(out_ready),
        .out_ctrl(ctl0), .out_data(dat0),
        .occupancy(occ0), .drop_cnt(drp0)
    );

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;
    bit hold = 1'b0;
    int drop1 = 0;
    int drop0 = 0;
    logic [103:0] q1[$];
    logic [103:0] q0[$];

    task automatic check(input string tag, input logic [95:0] obs,
                         input logic [95:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit mrdy1();
        return q1.size() < 2 && !freeze && !flush;
    endfunction

    function automatic bit mrdy0();
        return (q0.size() == 0 || out_ready) && !freeze && !flush;
    endfunction

    function automatic int sat(input int v);
        return v > 255 ? 255 : v;
    endfunction

    task automatic compare();
        bit live;
        live = !freeze && !flush;
        check("s1_in_ready", 96'(rdy1), 96'(mrdy1()));
        check("s1_out_valid", 96'(val1), 96'(q1.size() > 0 && live));
        check("s1_out_ctrl", 96'(ctl1), q1.size() > 0 ? 96'(q1[0][103:96]) : 96'h0);
        check("s1_out_data", dat1, q1.size() > 0 ? q1[0][95:0] : 96'h0);
        check("s1_occupancy", 96'(occ1), 96'(q1.size()));
        check("s1_drop_cnt", 96'(drp1), 96'(drop1));
        check("s0_in_ready", 96'(rdy0), 96'(mrdy0()));
        check("s0_out_valid", 96'(val0), 96'(q0.size() > 0 && live));
        check("s0_out_ctrl", 96'(ctl0), q0.size() > 0 ? 96'(q0[0][103:96]) : 96'h0);
        check("s0_out_data", dat0, q0.size() > 0 ? q0[0][95:0] : 96'h0);
        check("s0_occupancy", 96'(occ0), 96'(q0.size()));
        check("s0_drop_cnt", 96'(drp0), 96'(drop0));
    endtask

    task automatic step_model();
        bit a1, a0, d1, d0;
        a1 = in_valid && mrdy1();
        a0 = in_valid && mrdy0();
        d1 = q1.size() > 0 && !freeze && !flush && out_ready;
        d0 = q0.size() > 0 && !freeze && !flush && out_ready;
        hold = in_valid && !(a1 && a0);
        if (!rst) begin
            q1.delete();
            q0.delete();
            drop1 = 0;
            drop0 = 0;
            armed = 1'b1;
        end else if (flush) begin
            drop1 = sat(drop1 + q1.size());
            drop0 = sat(drop0 + q0.size());
            q1.delete();
            q0.delete();
        end else if (!freeze) begin
            if (d1) void'(q1.pop_front());
            if (d0) void'(q0.pop_front());
            if (a1) q1.push_back({in_ctrl, in_data});
            if (a0) q0.push_back({in_ctrl, in_data});
        end
    endtask

    task automatic cyc(input int r, input int fl, input int fz, input int iv,
                       input int c, input logic [95:0] d, input int ordy);
        @(negedge clk);
        rst       = (r != 0);
        flush     = (fl != 0);
        freeze    = (fz != 0);
        in_valid  = (iv != 0);
        in_ctrl   = 8'(c);
        in_data   = d;
        out_ready = (ordy != 0);
        #1;
        if (armed) compare();
        @(posedge clk);
        step_model();
    endtask

    initial begin
        // reset, with a handshake offered during reset
        cyc(0, 0, 0, 0, 0, 96'h0, 0);
        cyc(0, 0, 0, 1, 'hEE, 96'h1, 1);
        #1;
        check("rst_occupancy", 96'(occ1), 96'h0);
        check("rst_out_valid", 96'(val1), 96'h0);
        check("rst_out_ctrl", 96'(ctl1), 96'h0);
        check("rst_out_data", dat1, 96'h0);
        check("rst_drop_cnt", 96'(drp1), 96'h0);
        check("rst_in_ready", 96'(rdy1), 96'h1);

        // streaming
        for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 1, i, 96'(i), 1);
        repeat (2) cyc(1, 0, 0, 0, 0, 96'h0, 1);

        // backpressure fills the skid slot
        cyc(1, 0, 0, 1, 'h11, 96'hA, 0);
        cyc(1, 0, 0, 1, 'h22, 96'hB, 0);
        #1;
        check("bp_occupancy", 96'(occ1), 96'h2);
        check("bp_in_ready", 96'(rdy1), 96'h0);
        repeat (3) cyc(1, 0, 0, 0, 0, 96'h0, 1);

        // flush a full buffer, with a competing input
        cyc(1, 0, 0, 1, 'h61, 96'h61, 0);
        cyc(1, 0, 0, 1, 'h62, 96'h62, 0);
        cyc(1, 1, 0, 1, 'h33, 96'h33, 0);
        #1;
        check("fl_occupancy", 96'(occ1), 96'h0);
        check("fl_out_ctrl", 96'(ctl1), 96'h0);
        check("fl_drop_cnt", 96'(drp1), 96'h2);
        cyc(1, 0, 0, 0, 0, 96'h0, 1);

        // freeze holds one entry
        cyc(1, 0, 0, 1, 'h44, 96'h44, 0);
        repeat (3) begin
            cyc(1, 0, 1, 1, 'h55, 96'h55, 1);
            #1;
            check("fz_out_ctrl", 96'(ctl1), 96'h44);
        end
        cyc(1, 0, 0, 0, 0, 96'h0, 1);
        #1;
        check("fz_drained", 96'(occ1), 96'h0);

        // reset mid-stream with drop_cnt at 5
        cyc(1, 0, 0, 1, 'h71, 96'h71, 0);
        cyc(1, 0, 0, 1, 'h72, 96'h72, 0);
        cyc(1, 1, 0, 0, 0, 96'h0, 0);
        cyc(1, 0, 0, 1, 'h73, 96'h73, 0);
        cyc(1, 1, 0, 0, 0, 96'h0, 0);
        cyc(1, 0, 0, 1, 'h74, 96'h74, 0);
        cyc(1, 0, 0, 1, 'h75, 96'h75, 0);
        #1;
        check("mr_pre_drop", 96'(drp1), 96'h5);
        check("mr_pre_occ", 96'(occ1), 96'h2);
        cyc(0, 0, 0, 1, 'h76, 96'h76, 1);
        #1;
        check("mr_occupancy", 96'(occ1), 96'h0);
        check("mr_out_ctrl", 96'(ctl1), 96'h0);
        check("mr_out_data", dat1, 96'h0);
        check("mr_drop_cnt", 96'(drp1), 96'h0);
        cyc(1, 0, 0, 0, 0, 96'h0, 1);

        // single-register build: streaming, then same-cycle backpressure
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 'h80 + i, 96'(i + 16), 1);
        cyc(1, 0, 0, 0, 0, 96'h0, 1);
        cyc(1, 0, 0, 1, 'h90, 96'h90, 0);
        #1;
        check("s0_full_ready", 96'(rdy0), 96'h0);
        cyc(1, 0, 0, 1, 'h91, 96'h91, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 96'h0, 1);

        // drop counter saturation
        repeat (300) begin
            cyc(1, 0, 0, 1, 'hA5, 96'h5, 0);
            cyc(1, 1, 0, 0, 0, 96'h0, 0);
        end
        #1;
        check("sat_drop_s0", 96'(drp0), 96'hFF);
        check("sat_drop_s1", 96'(drp1), 96'hFF);

        // randomized traffic
        repeat (3000) begin
            int r, fl, fz, iv, ordy, c;
            logic [95:0] d;
            r    = ($urandom_range(0, 99) != 0) ? 1 : 0;
            fl   = ($urandom_range(0, 19) == 0) ? 1 : 0;
            fz   = ($urandom_range(0, 9) == 0) ? 1 : 0;
            iv   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            ordy = ($urandom_range(0, 2) != 0) ? 1 : 0;
            if (hold) begin
                c = int'(in_ctrl);
                d = in_data;
                iv = 1;
            end else begin
                c = int'($urandom_range(0, 255));
                d = pack_id_ex($urandom, $urandom, 24'($urandom),
                               4'($urandom), 4'($urandom));
            end
            cyc(r, fl, fz, iv, c, d, ordy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline-stage register; generalises the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Payload is split into a control field, zeroed on any bubble, and a data field.
- Adds a valid/ready handshake, an optional 2-entry skid buffer for full throughput with registered ready, flush/freeze priority rules, occupancy output and a saturating flush-drop counter.
- Instanced between any two pipeline stages.

Parameters:
- CTRL_W, 8: control-bit width (wb_en, mem_r_en, mem_w_en, status_w_en, branch_taken, imm, etc.); forced to 0 whenever the stage holds no valid entry.
- DATA_W, 96: data-field width (pc, val_rm, signed_immed_24, dest, exec_cmd packed by the instantiating stage).
- SKID, 1: 1 selects the 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational ready pass-through.
- CNT_W, 8: width of the flush-drop counter.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- flush, input, 1: discard all held entries; highest priority after reset.
- freeze, input, 1: hold all state.
- in_valid, input, 1: upstream entry present.
- in_ready, output, 1: stage can accept an entry this cycle.
- in_ctrl, input, CTRL_W: upstream control field.
- in_data, input, DATA_W: upstream data field.
- out_valid, output, 1: entry presented downstream.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: control field of the head entry; 0 when the head slot is empty.
- out_data, output, DATA_W: data field of the head entry; 0 when the head slot is empty.
- occupancy, output, 2: number of valid entries (0..2; maximum 1 when SKID=0).
- drop_cnt, output, CNT_W: count of valid entries discarded by flush; saturating.

Behaviour:
- State: head slot M (valid bit, ctrl, data) and, when SKID=1, skid slot S (valid bit, ctrl, data).
- Reset (rst=0 at a posedge): M and S invalid, all ctrl/data zeroed, drop_cnt=0.
  - Output values after reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready reads 1 after reset. Handshakes in the reset cycle are ignored.
- Priority at each posedge: reset > flush > freeze > normal.
- Handshake signals:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - Upstream must hold in_ctrl/in_data stable while in_valid=1 and in_ready=0.
- Combinational outputs:
  - out_valid = M.valid & ~freeze & ~flush.
  - out_ctrl and out_data are the M fields.
- in_ready, SKID=1: ~S.valid & ~freeze & ~flush. S.valid is registered, so in_ready has no combinational path from out_ready.
- in_ready, SKID=0: (~M.valid | out_ready) & ~freeze & ~flush.
- Flush:
  - Next cycle M and S are invalid and their ctrl/data are zeroed.
  - Any same-cycle in_valid is not accepted (in_ready=0).
  - drop_cnt += M.valid + S.valid, saturating at 2^CNT_W-1.
- Freeze:
  - All state holds; no accept and no drain (both ready and valid are masked).
  - out_ctrl/out_data stay stable.
- Normal operation, SKID=1:
  - drain and S.valid: M <= S; S cleared.
  - drain, S empty, accept: M <= input.
  - drain, S empty, no accept: M cleared, ctrl/data zeroed.
  - no drain, accept, M empty: M <= input.
  - no drain, accept, M valid: S <= input.
  - otherwise: hold.
- Normal operation, SKID=0: M <= input on accept; M cleared on drain without accept.
- Throughput and latency:
  - Throughput is one entry per cycle when out_ready stays at 1.
  - Latency is 1 cycle from accept to out_valid.
- occupancy = M.valid + S.valid, registered.
- Ordering: entries leave strictly in FIFO order and are never duplicated.
- Reset asserted mid-stream clears everything without incrementing drop_cnt.

Decomposition:
- Package pipe_pkg:
  - Per-stage ctrl/data widths as localparams (ID_CTRL_W, ID_DATA_W, …).
  - Bit-index constants for the standard control bits (CTRL_WB_EN, CTRL_MEM_R, CTRL_MEM_W, CTRL_S, CTRL_B, CTRL_IMM).
  - A function packing the ID/EX fields into a data word.
- Sub-module pipe_slot: one valid+ctrl+data register with load/clear/hold controls and zero-on-clear. Instanced once (M) or twice (M, S).

Test Plan:
- Streaming: SKID=1, out_ready=1, send ctrl=0x01..0x05 with data=1..5 back-to-back from a posedge after reset release -> out_valid from the cycle after the first accept, values in order, in_ready constantly 1, occupancy 1.
- Backpressure: out_ready=0, send A=0x11, B=0x22 -> occupancy 2 and in_ready 0 after B; release out_ready -> A then B, no loss or duplication; in_ready=1 the cycle after S drains.
- Flush with full buffer: two entries held, flush=1 for one cycle with in_valid=1, ctrl=0x33 -> next cycle out_valid=0, out_ctrl=0, occupancy 0, drop_cnt=2, 0x33 not accepted.
- Freeze: one entry held (ctrl=0x44), freeze=1 for 3 cycles with out_ready=1 and in_valid=1 -> out_valid=0, in_ready=0, out_ctrl stays 0x44; freeze released -> 0x44 drains next cycle.
- Reset mid-operation: two entries held with drop_cnt=5, then rst=0 for one cycle -> occupancy 0, out_ctrl=0, out_data=0, drop_cnt=0, in_ready=1 afterwards.
- SKID=0 build: with out_ready=1 send 4 back-to-back entries -> 1 per cycle; with out_ready=0 and M full -> in_ready=0 in the same cycle; drop_cnt saturates at 255 after 300 flushes with M valid.
